memio_arbiter: RTL and testbench
================================

Name: memio_arbiter

Overview:
- Two-master arbiter and sequencer for the SoC memory/IO bus: 12-bit address, 16-bit data, one shared bootrom/SPI target set.
- Master 0 is the CPU; master 1 is a secondary requester (debug/serial loader).
- Grants the bus round-robin, decodes the address into bootrom chip-select or SPI load/unload strobes, and inserts per-target wait states.
- Returns registered read data with a one-cycle ack to the owning master.

Parameters:
- AW, 12, address width.
- DW, 16, data width.
- BOOT_WAIT, 0, extra wait cycles for bootrom accesses (0..15).
- SPI_WAIT, 2, extra wait cycles for SPI accesses (0..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request; held high until m0_ack.
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_rdata  out  DW  master 0 read data, registered.
- m0_ack  out  1  master 0 completion pulse.
- m1_req, m1_addr, m1_wdata, m1_we, m1_rdata, m1_ack: same as master 0, for master 1.
- bus_addr  out  AW  latched address to targets.
- bus_wdata  out  DW  latched write data to targets.
- bus_we  out  1  latched write enable.
- boot_cs  out  1  bootrom select.
- spi_load  out  1  SPI write strobe.
- spi_unload  out  1  SPI read strobe.
- boot_rdata  in  DW  bootrom read data.
- spi_rdata  in  8  SPI read data.
- owner  out  2  one-hot current bus owner; 00 when idle.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. All outputs are 0: owner, boot_cs, spi_load, spi_unload, both acks, both rdata, bus_addr, bus_wdata, bus_we.
  - The last-grant pointer is set to master 1, so master 0 wins the first tie.
  - Asserting reset mid-access drops all strobes immediately. The access is lost and no ack is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If exactly one request is present, grant it.
  - If both requests are present, grant the master that was NOT granted last.
  - On grant: latch addr, wdata and we from the winning master; set owner; update the last-grant pointer; go to ACCESS.
  - Load wait counter with BOOT_WAIT if addr[11:4]==0, otherwise with SPI_WAIT.
- ACCESS:
  - Target select is decoded from the latched address. Boot target: addr[11:4]==0. SPI target: any other address.
  - boot_cs is high for the whole ACCESS phase.
  - spi_load (we=1) or spi_unload (we=0) is high for exactly the first ACCESS cycle only.
  - While the counter is non-zero, decrement it.
  - When the counter is 0 and the access is a read, capture read data into the owner's rdata:
    - SPI target: {8'h00, spi_rdata}.
    - Boot target: boot_rdata.
  - Then go to DONE.
  - Write accesses leave rdata unchanged.
- DONE:
  - Owner's ack is high for this single cycle; boot_cs is 0; owner remains set.
  - Next state is IDLE and owner clears to 00.
- Latency: request seen in IDLE at edge N; ACCESS from N+1; ack high from edge N+2+W to N+3+W, where W is the selected wait value.
- Master protocol: the master drops req, or presents a new transaction, after sampling ack. Arbitration re-evaluates in IDLE, so the minimum repeat interval per master is 3+W cycles.
- Requests changing while not in IDLE are ignored.
- The non-owning master's rdata holds its last value.
- A request arriving at the same edge as another master's DONE is served at the next IDLE, with round-robin applied.

Test Plan:
- Reset, then m0 reads addr 0x003 with boot_rdata=0xBEEF and BOOT_WAIT=0 -> boot_cs high 1 cycle, m0_ack 2 cycles after request, m0_rdata=0xBEEF, m1_ack stays 0.
- m1 writes 0x0A5 to addr 0x010 with SPI_WAIT=2 -> spi_load a single-cycle pulse, bus_wdata=0x00A5, m1_ack at cycle 4 after request, m1_rdata unchanged.
- m0 reads addr 0x020 with spi_rdata=0x5C -> spi_unload single pulse, m0_rdata=0x005C.
- Both masters request continuously after reset -> grants alternate m0, m1, m0, m1; owner is never 11.
- rst_n pulsed low during an SPI ACCESS -> strobes and owner go 0 immediately, no ack, next request proceeds normally with m0 priority.
- m0 read of boot addr 0x00F then SPI addr 0x100 back-to-back -> decode switches targets, wait lengths 0 and SPI_WAIT respectively.

Source files
------------

// File: rtl/memio_arbiter.sv
// Two-master round-robin arbiter for the memory/IO bus: decodes bootrom vs SPI targets,
// inserts per-target wait states and returns registered read data with a one-cycle ack.
module memio_arbiter #(
   parameter int unsigned AW        = 12,
   parameter int unsigned DW        = 16,
   parameter int unsigned BOOT_WAIT = 0,
   parameter int unsigned SPI_WAIT  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_we,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_we,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ack,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   output logic          bus_we,
   output logic          boot_cs,
   output logic          spi_load,
   output logic          spi_unload,
   input  logic [DW-1:0] boot_rdata,
   input  logic [7:0]    spi_rdata,
   output logic [1:0]    owner
);

   localparam logic [3:0] BootW = 4'(BOOT_WAIT);
   localparam logic [3:0] SpiW  = 4'(SPI_WAIT);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e        state_q, state_d;
   logic [1:0]    owner_q, owner_d;
   logic          last_q, last_d;  // 1: master 1 was granted last
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          we_q, we_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          boot_cs_q, boot_cs_d;
   logic          spi_load_q, spi_load_d;
   logic          spi_unload_q, spi_unload_d;
   logic          m0_ack_q, m0_ack_d;
   logic          m1_ack_q, m1_ack_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;

   logic          grant_m1;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_we;
   logic          sel_boot;
   logic          acc_boot;
   logic [DW-1:0] rd_data;

   // Master 1 wins when alone, or on a tie when master 0 was granted last.
   assign grant_m1  = m1_req & (~m0_req | ~last_q);
   assign sel_addr  = grant_m1 ? m1_addr  : m0_addr;
   assign sel_wdata = grant_m1 ? m1_wdata : m0_wdata;
   assign sel_we    = grant_m1 ? m1_we    : m0_we;
   assign sel_boot  = (sel_addr[AW-1:4] == '0);
   assign acc_boot  = (addr_q[AW-1:4] == '0);
   assign rd_data   = acc_boot ? boot_rdata : {{(DW-8){1'b0}}, spi_rdata};

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      boot_cs_d    = boot_cs_q;
      spi_load_d   = 1'b0;
      spi_unload_d = 1'b0;
      m0_ack_d     = 1'b0;
      m1_ack_d     = 1'b0;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (m0_req || m1_req) begin
               owner_d      = grant_m1 ? 2'b10 : 2'b01;
               last_d       = grant_m1;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               we_d         = sel_we;
               cnt_d        = sel_boot ? BootW : SpiW;
               boot_cs_d    = sel_boot;
               spi_load_d   = ~sel_boot & sel_we;
               spi_unload_d = ~sel_boot & ~sel_we;
               state_d      = StAccess;
            end
         end
         StAccess: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               boot_cs_d = 1'b0;
               if (!we_q) begin
                  if (owner_q[0]) m0_rdata_d = rd_data;
                  if (owner_q[1]) m1_rdata_d = rd_data;
               end
               m0_ack_d = owner_q[0];
               m1_ack_d = owner_q[1];
               state_d  = StDone;
            end
         end
         StDone: begin
            owner_d = 2'b00;
            state_d = StIdle;
         end
         default: begin
            owner_d   = 2'b00;
            boot_cs_d = 1'b0;
            state_d   = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         owner_q      <= 2'b00;
         last_q       <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         cnt_q        <= 4'd0;
         boot_cs_q    <= 1'b0;
         spi_load_q   <= 1'b0;
         spi_unload_q <= 1'b0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         boot_cs_q    <= boot_cs_d;
         spi_load_q   <= spi_load_d;
         spi_unload_q <= spi_unload_d;
         m0_ack_q     <= m0_ack_d;
         m1_ack_q     <= m1_ack_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign owner      = owner_q;
   assign bus_addr   = addr_q;
   assign bus_wdata  = wdata_q;
   assign bus_we     = we_q;
   assign boot_cs    = boot_cs_q;
   assign spi_load   = spi_load_q;
   assign spi_unload = spi_unload_q;
   assign m0_ack     = m0_ack_q;
   assign m1_ack     = m1_ack_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_memio_arbiter.sv
// Directed bench for memio_arbiter: boot/SPI decode, wait states, round-robin and reset abort.
module tb_memio_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [11:0] m0_addr = '0, m1_addr = '0;
   logic [15:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [15:0] m0_rdata, m1_rdata;
   logic        m0_ack, m1_ack;
   logic [11:0] bus_addr;
   logic [15:0] bus_wdata;
   logic        bus_we;
   logic        boot_cs, spi_load, spi_unload;
   logic [15:0] boot_rdata = '0;
   logic [7:0]  spi_rdata = '0;
   logic [1:0]  owner;

   int n_cmp = 0;
   int n_err = 0;

   memio_arbiter #(.AW(12), .DW(16), .BOOT_WAIT(0), .SPI_WAIT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
      .boot_cs(boot_cs), .spi_load(spi_load), .spi_unload(spi_unload),
      .boot_rdata(boot_rdata), .spi_rdata(spi_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({owner, boot_cs, spi_load, spi_unload, m0_ack, m1_ack, bus_we} !== 8'h00) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 00000000",
                  {owner, boot_cs, spi_load, spi_unload, m0_ack, m1_ack, bus_we});
      end
      n_cmp++;
      if ({m0_rdata, m1_rdata, bus_wdata, bus_addr} !== 60'h0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 0", {m0_rdata, m1_rdata, bus_wdata, bus_addr});
      end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_boot_read();
      m0_req = 1'b1; m0_addr = 12'h003; m0_we = 1'b0; boot_rdata = 16'hBEEF;
      cyc();
      n_cmp++;
      if ({owner, boot_cs, m0_ack, bus_addr} !== {2'b01, 1'b1, 1'b0, 12'h003}) begin
         n_err++;
         $display("FAIL boot_grant: got owner=%b cs=%b ack=%b addr=%h want 01 1 0 003",
                  owner, boot_cs, m0_ack, bus_addr);
      end
      cyc();
      m0_req = 1'b0;
      n_cmp++;
      if ({m0_ack, m1_ack, boot_cs, owner} !== {1'b1, 1'b0, 1'b0, 2'b01}) begin
         n_err++;
         $display("FAIL boot_ack: got ack0=%b ack1=%b cs=%b owner=%b want 1 0 0 01",
                  m0_ack, m1_ack, boot_cs, owner);
      end
      n_cmp++;
      if (m0_rdata !== 16'hBEEF) begin
         n_err++;
         $display("FAIL boot_rdata: got %h want beef", m0_rdata);
      end
      cyc();
      n_cmp++;
      if ({owner, m0_ack} !== 3'b000) begin
         n_err++;
         $display("FAIL boot_idle: got owner=%b ack=%b want 00 0", owner, m0_ack);
      end
   endtask

   task automatic test_spi_write();
      m1_req = 1'b1; m1_addr = 12'h010; m1_wdata = 16'h00A5; m1_we = 1'b1;
      cyc();
      n_cmp++;
      if ({owner, spi_load, spi_unload, boot_cs, bus_we} !== 6'b10_1001) begin
         n_err++;
         $display("FAIL spiw_grant: got owner=%b ld=%b unld=%b cs=%b we=%b want 10 1 0 0 1",
                  owner, spi_load, spi_unload, boot_cs, bus_we);
      end
      n_cmp++;
      if (bus_wdata !== 16'h00A5) begin
         n_err++;
         $display("FAIL spiw_wdata: got %h want 00a5", bus_wdata);
      end
      cyc();
      n_cmp++;
      if ({spi_load, m1_ack} !== 2'b00) begin
         n_err++;
         $display("FAIL spiw_pulse: got ld=%b ack=%b want 0 0", spi_load, m1_ack);
      end
      cyc();
      n_cmp++;
      if (m1_ack !== 1'b0) begin
         n_err++;
         $display("FAIL spiw_wait: got ack=%b want 0", m1_ack);
      end
      cyc();
      m1_req = 1'b0;
      n_cmp++;
      if ({m1_ack, m0_ack, m1_rdata} !== {1'b1, 1'b0, 16'h0000}) begin
         n_err++;
         $display("FAIL spiw_ack: got ack1=%b ack0=%b rdata1=%h want 1 0 0000",
                  m1_ack, m0_ack, m1_rdata);
      end
      cyc();
   endtask

   task automatic test_spi_read();
      m0_req = 1'b1; m0_addr = 12'h020; m0_we = 1'b0; spi_rdata = 8'h5C;
      cyc();
      n_cmp++;
      if ({owner, spi_unload, spi_load, boot_cs} !== 5'b01_100) begin
         n_err++;
         $display("FAIL spir_grant: got owner=%b unld=%b ld=%b cs=%b want 01 1 0 0",
                  owner, spi_unload, spi_load, boot_cs);
      end
      cyc();
      n_cmp++;
      if (spi_unload !== 1'b0) begin
         n_err++;
         $display("FAIL spir_pulse: got unld=%b want 0", spi_unload);
      end
      cyc();
      cyc();
      m0_req = 1'b0;
      n_cmp++;
      if ({m0_ack, m0_rdata, m1_rdata} !== {1'b1, 16'h005C, 16'h0000}) begin
         n_err++;
         $display("FAIL spir_ack: got ack=%b rdata0=%h rdata1=%h want 1 005c 0000",
                  m0_ack, m0_rdata, m1_rdata);
      end
      cyc();
   endtask

   task automatic test_round_robin();
      int         grants;
      logic [1:0] prev;
      logic [1:0] want;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      m0_req = 1'b1; m0_addr = 12'h001; m0_we = 1'b0;
      m1_req = 1'b1; m1_addr = 12'h002; m1_we = 1'b0;
      boot_rdata = 16'h1111;
      grants = 0;
      prev = 2'b00;
      for (int c = 0; c < 40 && grants < 4; c++) begin
         cyc();
         if (owner == 2'b11) begin
            n_cmp++;
            n_err++;
            $display("FAIL rr_onehot: got owner=%b want not 11", owner);
         end
         if (owner != 2'b00 && prev == 2'b00) begin
            want = (grants % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (owner !== want) begin
               n_err++;
               $display("FAIL rr_grant%0d: got owner=%b want %b", grants, owner, want);
            end
            grants++;
         end
         prev = owner;
      end
      n_cmp++;
      if (grants != 4) begin
         n_err++;
         $display("FAIL rr_count: got %0d grants want 4", grants);
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic test_reset_mid_access();
      m0_req = 1'b1; m0_addr = 12'h030; m0_we = 1'b0; spi_rdata = 8'h99;
      cyc();
      n_cmp++;
      if ({owner, spi_unload} !== 3'b01_1) begin
         n_err++;
         $display("FAIL rst_pre: got owner=%b unld=%b want 01 1", owner, spi_unload);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({owner, spi_unload, spi_load, boot_cs, m0_ack, m0_rdata} !== 22'h0) begin
         n_err++;
         $display("FAIL rst_abort: got owner=%b unld=%b ld=%b cs=%b ack=%b rdata=%h want all 0",
                  owner, spi_unload, spi_load, boot_cs, m0_ack, m0_rdata);
      end
      cyc();
      cyc();
      n_cmp++;
      if ({m0_ack, owner} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_noack: got ack=%b owner=%b want 0 00", m0_ack, owner);
      end
      rst_n = 1'b1;
      m0_addr = 12'h005; boot_rdata = 16'h2222;
      m1_req = 1'b1; m1_addr = 12'h006; m1_we = 1'b0;
      cyc();
      n_cmp++;
      if (owner !== 2'b01) begin
         n_err++;
         $display("FAIL rst_prio: got owner=%b want 01", owner);
      end
      cyc();
      m0_req = 1'b0;
      m1_req = 1'b0;
      n_cmp++;
      if ({m0_ack, m0_rdata} !== {1'b1, 16'h2222}) begin
         n_err++;
         $display("FAIL rst_next: got ack=%b rdata=%h want 1 2222", m0_ack, m0_rdata);
      end
      repeat (2) cyc();
   endtask

   task automatic test_back_to_back();
      int wait_cyc;
      m0_req = 1'b1; m0_addr = 12'h00F; m0_we = 1'b0; boot_rdata = 16'h1234;
      spi_rdata = 8'hA7;
      cyc();
      n_cmp++;
      if ({owner, boot_cs, spi_unload} !== 4'b01_10) begin
         n_err++;
         $display("FAIL b2b_boot: got owner=%b cs=%b unld=%b want 01 1 0",
                  owner, boot_cs, spi_unload);
      end
      cyc();
      n_cmp++;
      if ({m0_ack, m0_rdata} !== {1'b1, 16'h1234}) begin
         n_err++;
         $display("FAIL b2b_boot_ack: got ack=%b rdata=%h want 1 1234 after 0 waits",
                  m0_ack, m0_rdata);
      end
      m0_addr = 12'h100;
      cyc();
      n_cmp++;
      if ({owner, m0_ack} !== 3'b000) begin
         n_err++;
         $display("FAIL b2b_idle: got owner=%b ack=%b want 00 0", owner, m0_ack);
      end
      cyc();
      n_cmp++;
      if ({owner, boot_cs, spi_unload, bus_addr} !== {2'b01, 1'b0, 1'b1, 12'h100}) begin
         n_err++;
         $display("FAIL b2b_spi: got owner=%b cs=%b unld=%b addr=%h want 01 0 1 100",
                  owner, boot_cs, spi_unload, bus_addr);
      end
      wait_cyc = 0;
      for (int c = 0; c < 10 && m0_ack !== 1'b1; c++) begin
         cyc();
         wait_cyc++;
      end
      m0_req = 1'b0;
      n_cmp++;
      if (wait_cyc != 3) begin
         n_err++;
         $display("FAIL b2b_spi_wait: got ack after %0d cycles want 3", wait_cyc);
      end
      n_cmp++;
      if (m0_rdata !== 16'h00A7) begin
         n_err++;
         $display("FAIL b2b_spi_rdata: got %h want 00a7", m0_rdata);
      end
      repeat (2) cyc();
   endtask

   initial begin
      test_reset();
      test_boot_read();
      test_spi_write();
      test_spi_read();
      test_round_robin();
      test_reset_mid_access();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
